uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Byte FIFO directly downstream of the uart_core receiver; consumes data_out/data_out_valid and drives data_out_ready.
- Decouples the receiver's single-byte holding register from a slow consumer (MMIO/CPU load path) so bytes arriving back-to-back at 115200 baud are not lost.
- Ready/valid on both sides, synchronous single-clock, with level/full/empty status.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, minimum 2.
- DATA_W, 8, entry width in bits; matches the uart_core byte width.

Ports:
- clk  in  1  system clock, 125 MHz nominal.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO in one cycle.
- in_data  in  DATA_W  byte from uart_core data_out.
- in_valid  in  1  from uart_core data_out_valid.
- in_ready  out  1  to uart_core data_out_ready.
- out_data  out  DATA_W  oldest stored byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.

Behaviour:
- Reset (async assert, released synchronously by the system): write ptr = 0, read ptr = 0, level = 0, out_valid = 0, in_ready = 1, full = 0, empty = 1, out_data = 0. Storage is not reset.
- Pointers are $clog2(DEPTH)+1 bits, with the extra MSB as wrap bit.
  - empty when ptrs are equal.
  - full when indices are equal and wrap bits differ.
  - Indices wrap DEPTH-1 -> 0.
- in_ready = !full. out_valid = !empty. Both are combinational from registered state only; no comb path from in_valid to out_valid and none from out_ready to in_ready.
- Push: in_valid && in_ready at a posedge.
  - Write in_data at the write index; increment write ptr.
  - Latency: a byte pushed at edge N shows on out_valid/out_data after edge N; the first edge that can pop it is N+1.
- Pop: out_valid && out_ready at a posedge; increment read ptr.
  - out_data = mem[read index], read asynchronously from registered storage.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - When empty, out_data holds the last popped value (0 after reset).
- Push and pop in the same cycle (0 < level < DEPTH): both occur and level is unchanged.
  - When empty, only the push occurs.
  - When full, only the pop occurs; in_ready was 0, so there is no pass-through and no bypass.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- clear: wins over push and pop in the same cycle. Both ptrs = 0 and level = 0 next cycle. A byte offered that cycle is not accepted (in_ready is still reported as !full). Storage is untouched.
- Reset mid-operation: all contents are discarded immediately (async). uart_core sees in_ready=1 after reset.
- No state machine beyond the pointer/level registers.

Optional Feature:
- Macro: UART_RX_FIFO_WATERMARK_EN.
- With the macro defined:
  - Parameter WM_LEVEL (default DEPTH/2) is added.
  - Output watermark (1 bit) is added; it is registered, resets to 0, and is set the cycle after level >= WM_LEVEL.
  - Intended as an interrupt/DMA request to the consumer.
- Without the macro: neither the port nor the parameter exists, and no extra flops are inferred.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8, with typedef uart_byte_t (logic [UART_DATA_W-1:0]).
  - Default UART_RX_FIFO_DEPTH = 16.
  - The CLOCK_FREQ/BAUD_RATE defaults shared with uart_core.
- One sub-module is natural: uart_fifo_mem.
  - DEPTH x DATA_W register array.
  - Synchronous write port, asynchronous read port.
  - Reusable for a future TX-side FIFO ahead of uart_core data_in.

Test Plan:
- Reset then idle: level=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=8'h00.
- Push 8'h11..8'h1A (10 bytes) with out_ready=0, then drain with out_ready=1: level reaches 10; bytes pop in order 11..1A one per cycle; empty=1 after the 10th pop.
- Push 16 bytes 8'h20..8'h2F with DEPTH=16: full=1 and in_ready=0. A 17th byte 8'hFF offered for 5 cycles is not accepted. Popping once gives 8'h20 and in_ready returns to 1 next cycle.
- Push and pop every cycle at level=3 for 20 cycles: level stays 3 and output order is preserved. Ptrs wrap past index 15 without corruption.
- clear asserted with level=7 while in_valid=1 and out_ready=1: next cycle level=0 and empty=1; the offered byte is lost and no pop is counted.
- Instantiate behind a uart_core receiver pair, send 8'h11..8'h1A over serial with out_ready held low, then drain: all 10 bytes are received in order with no loss. With UART_RX_FIFO_WATERMARK_EN and WM_LEVEL=8, watermark=1 the cycle after level reaches 8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_core and the receive FIFO.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int CLOCK_FREQ         = 125_000_000;
    localparam int BAUD_RATE          = 115_200;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps onto plain flops/LUTRAM.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming entry on a write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the uart_core receiver and a slow consumer.
// Optional feature: define UART_RX_FIFO_WATERMARK_EN to add the WM_LEVEL
// parameter and the registered watermark output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    parameter int WM_LEVEL = DEPTH / 2
`endif
) (
`ifdef UART_RX_FIFO_WATERMARK_EN
    output logic                       watermark,
`endif
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Status flags derived purely from the registered pointers.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
        in_ready  = !full;
        out_valid = !empty;
        level     = wr_ptr_q - rd_ptr_q;
        if (empty) begin
            out_data = last_q;
        end else begin
            out_data = rd_data;
        end
    end

    // Handshake decode and next pointer state; clear overrides both sides.
    always_comb begin
        push     = in_valid && !full && !clear;
        pop      = out_ready && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                last_d   = rd_data;
            end else begin
                rd_ptr_d = rd_ptr_q;
                last_d   = last_q;
            end
        end
    end

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic wm_q, wm_d;

    // Watermark request follows the occupancy threshold one cycle later.
    always_comb begin
        if (level >= ($clog2(DEPTH)+1)'(WM_LEVEL)) begin
            wm_d = 1'b1;
        end else begin
            wm_d = 1'b0;
        end
    end

    // Watermark register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wm_q <= 1'b0;
        end else begin
            wm_q <= wm_d;
        end
    end

    assign watermark = wm_q;
`endif

    // Pointer and last-popped-byte registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int WM    = DEPTH / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic          watermark;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [7:0] q[$];
    logic [7:0] last_pop = 8'h00;
    logic       wm_exp = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
`ifdef UART_RX_FIFO_WATERMARK_EN
        .watermark (watermark),
`endif
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        do_push   = v && (q.size() < DEPTH) && !c;
        do_pop    = r && (q.size() > 0) && !c;
        @(posedge clk);
        #1;
        wm_exp = (q.size() >= WM);
        if (c) begin
            q.delete();
        end else begin
            if (do_pop) last_pop = q.pop_front();
            if (do_push) q.push_back(d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (level !== LW'(0)) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] b;
        for (int i = 0; i < 10; i++) begin
            b = 8'h11 + 8'(i);
            step(1'b1, b, 1'b0, 1'b0);
            n_cmp++; if (level !== LW'(i + 1)) begin n_err++; $display("FAIL fill_level: got %0d want %0d", level, i + 1); end
        end
        for (int i = 0; i < 10; i++) begin
            b = 8'h11 + 8'(i);
            n_cmp++; if (out_data !== b) begin n_err++; $display("FAIL drain_order: got %h want %h", out_data, b); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
        n_cmp++; if (out_data !== 8'h1A) begin n_err++; $display("FAIL drain_hold_last: got %h want 1a", out_data); end
    endtask

    task automatic test_full();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", full); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0);
            n_cmp++; if (level !== LW'(16)) begin n_err++; $display("FAIL full_no_accept: got %0d want 16", level); end
        end
        n_cmp++; if (out_data !== 8'h20) begin n_err++; $display("FAIL full_head: got %h want 20", out_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 8'h21) begin n_err++; $display("FAIL full_next_head: got %h want 21", out_data); end
        // drain the rest, checking the 8'hFF never got in
        for (int i = 0; i < 15; i++) begin
            n_cmp++; if (out_data !== q[0]) begin n_err++; $display("FAIL full_drain: got %h want %h", out_data, q[0]); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++; if (last_pop !== 8'h2F) begin n_err++; $display("FAIL full_model_tail: got %h want 2f", last_pop); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (out_data !== q[0]) begin n_err++; $display("FAIL b2b_order: got %h want %h", out_data, q[0]); end
            step(1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
            n_cmp++; if (level !== LW'(3)) begin n_err++; $display("FAIL b2b_level: got %0d want 3", level); end
        end
    endtask

    task automatic test_clear();
        logic [7:0] held;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        n_cmp++; if (level !== LW'(7)) begin n_err++; $display("FAIL clear_pre_level: got %0d want 7", level); end
        held = last_pop;
        step(1'b1, 8'hAB, 1'b1, 1'b1);
        n_cmp++; if (level !== LW'(0)) begin n_err++; $display("FAIL clear_level: got %0d want 0", level); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL clear_empty: got %b want 1", empty); end
        n_cmp++; if (out_data !== held) begin n_err++; $display("FAIL clear_no_pop: got %h want %h", out_data, held); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
            n_cmp++; if (level !== LW'(q.size())) begin n_err++; $display("FAIL rnd_level: got %0d want %0d", level, q.size()); end
            n_cmp++; if (empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty: got %b", empty); end
            n_cmp++; if (full !== (q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full: got %b", full); end
            n_cmp++; if (in_ready !== (q.size() != DEPTH)) begin n_err++; $display("FAIL rnd_in_ready: got %b", in_ready); end
            n_cmp++; if (out_data !== ((q.size() != 0) ? q[0] : last_pop)) begin
                n_err++; $display("FAIL rnd_out_data: got %h want %h", out_data, (q.size() != 0) ? q[0] : last_pop);
            end
`ifdef UART_RX_FIFO_WATERMARK_EN
            n_cmp++; if (watermark !== wm_exp) begin n_err++; $display("FAIL rnd_watermark: got %b want %b", watermark, wm_exp); end
`endif
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        last_pop = 8'h00;
        n_cmp++; if (level !== LW'(0)) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL arst_out_data: got %h want 00", out_data); end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        n_cmp++; if (out_data !== 8'h99) begin n_err++; $display("FAIL arst_push_after: got %h want 99", out_data); end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_full();
        test_back_to_back();
        test_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
